// File: rtl/conv_pkg.sv
// Shared constants for the conv1 front end (window generator and filter bank).
// Pixels are float32 bit patterns carried as opaque words; nothing here
// interprets them.
package conv_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int IMG_WIDTH   = 28;
    localparam int IMG_HEIGHT  = 28;
    localparam int KERNEL_SIZE = 3;

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    typedef logic [DATA_WIDTH-1:0] pixel_t;

    // One window row, element 0 is the newest pixel.
    typedef logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] win_row_t;

endpackage

// File: rtl/conv_window_buf_if.sv
// Bus between the raster pixel source, the window generator and the filter.
//   valid_in, data_in            : pixel stream into the window generator
//   data_out_0..8                : 3x3 window, row-major, _8 is the newest pixel
//   valid_out_buf, frame_done    : window-complete pulse, last-window-of-frame pulse
// Handshake: valid_in=1 means data_in is consumed on that rising edge; there is
// no ready (the generator always accepts). valid_out_buf is a one-cycle pulse
// qualifying data_out_*; the consumer must take the window in that cycle.
interface conv_window_buf_if;
    import conv_pkg::*;

    logic   valid_in;
    pixel_t data_in;
    pixel_t data_out_0;
    pixel_t data_out_1;
    pixel_t data_out_2;
    pixel_t data_out_3;
    pixel_t data_out_4;
    pixel_t data_out_5;
    pixel_t data_out_6;
    pixel_t data_out_7;
    pixel_t data_out_8;
    logic   valid_out_buf;
    logic   frame_done;

    modport master (
        output valid_in, data_in,
        input  data_out_0, data_out_1, data_out_2, data_out_3, data_out_4,
               data_out_5, data_out_6, data_out_7, data_out_8,
               valid_out_buf, frame_done
    );

    modport slave (
        input  valid_in, data_in,
        output data_out_0, data_out_1, data_out_2, data_out_3, data_out_4,
               data_out_5, data_out_6, data_out_7, data_out_8,
               valid_out_buf, frame_done
    );

endinterface

// File: rtl/line_fifo.sv
// Enable-gated delay line: dout is the sample accepted exactly DEPTH enabled
// cycles ago. Used as a one-row line buffer.
//   clk, rst : clock, synchronous active-high reset (clears contents)
//   en       : shift in din this cycle
//   din      : sample in
//   dout     : sample DEPTH accepted samples old
module line_fifo #(
    parameter int DEPTH = 28,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [DEPTH-1:0][WIDTH-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (en) begin
            mem_d = {mem_q[DEPTH-2:0], din};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_buf.sv
// Streaming 3x3 window generator for conv1. Takes one pixel per accepted cycle
// in raster order and presents every fully-inside 3x3 window one cycle later.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of conv_window_buf_if (pixel in, window out)
module conv_window_buf
    import conv_pkg::*;
(
    input logic              clk,
    input logic              rst,
    conv_window_buf_if.slave bus
);

    pixel_t lb0_out;  // pixel one row above the incoming one
    pixel_t lb1_out;  // pixel two rows above the incoming one

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    win_row_t [KERNEL_SIZE-1:0] win_q, win_d;
    logic valid_q, valid_d;
    logic fdone_q, fdone_d;
    logic last_col, last_row;

    line_fifo #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH)) u_lb0 (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.valid_in),
        .din  (bus.data_in),
        .dout (lb0_out)
    );

    line_fifo #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH)) u_lb1 (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.valid_in),
        .din  (lb0_out),
        .dout (lb1_out)
    );

    assign last_col = (col_q == COL_W'(IMG_WIDTH - 1));
    assign last_row = (row_q == ROW_W'(IMG_HEIGHT - 1));

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        valid_d = 1'b0;
        fdone_d = 1'b0;
        if (bus.valid_in) begin
            // The window registers are the output registers, so they load the
            // column that includes the pixel arriving now.
            win_d[0] = {win_q[0][KERNEL_SIZE-2:0], lb1_out};
            win_d[1] = {win_q[1][KERNEL_SIZE-2:0], lb0_out};
            win_d[2] = {win_q[2][KERNEL_SIZE-2:0], bus.data_in};
            // col>=2 keeps windows from wrapping across a row edge; row>=2
            // keeps stale line-buffer / previous-frame data from escaping.
            valid_d = (row_q >= ROW_W'(KERNEL_SIZE - 1)) &&
                      (col_q >= COL_W'(KERNEL_SIZE - 1));
            fdone_d = last_row && last_col;
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            fdone_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            fdone_q <= fdone_d;
        end
    end

    // Row 0 of win_q is two rows up; element 2 of each row is the oldest column.
    assign bus.data_out_0    = win_q[0][2];
    assign bus.data_out_1    = win_q[0][1];
    assign bus.data_out_2    = win_q[0][0];
    assign bus.data_out_3    = win_q[1][2];
    assign bus.data_out_4    = win_q[1][1];
    assign bus.data_out_5    = win_q[1][0];
    assign bus.data_out_6    = win_q[2][2];
    assign bus.data_out_7    = win_q[2][1];
    assign bus.data_out_8    = win_q[2][0];
    assign bus.valid_out_buf = valid_q;
    assign bus.frame_done    = fdone_q;

endmodule

// File: tb/tb_conv_window_buf.sv
// Bench for conv_window_buf: reference model keeps the frame as a 2-D array
// and derives each expected window directly from pixel coordinates.
module tb_conv_window_buf;
    import conv_pkg::*;

    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int NWIN = (IMG_WIDTH - 2) * (IMG_HEIGHT - 2);
    localparam int EW   = 9 * DATA_WIDTH + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_window_buf_if bus ();

    conv_window_buf dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] dout [9];
    assign dout[0] = bus.data_out_0;
    assign dout[1] = bus.data_out_1;
    assign dout[2] = bus.data_out_2;
    assign dout[3] = bus.data_out_3;
    assign dout[4] = bus.data_out_4;
    assign dout[5] = bus.data_out_5;
    assign dout[6] = bus.data_out_6;
    assign dout[7] = bus.data_out_7;
    assign dout[8] = bus.data_out_8;

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [31:0]   img [IMG_HEIGHT][IMG_WIDTH];
    int            pix_idx = 0;
    int            edges = 0;
    bit            edge_rst, edge_acc;
    int            mr, mc;
    logic [EW-1:0] e_new, e_mon;

    always @(posedge clk) begin
        edges++;
        edge_rst = rst;
        edge_acc = bus.valid_in && !rst;
        if (rst) begin
            pix_idx = 0;
            exp_q.delete();
        end else if (bus.valid_in) begin
            mr = pix_idx / IMG_WIDTH;
            mc = pix_idx % IMG_WIDTH;
            img[mr][mc] = bus.data_in;
            if (mr >= 2 && mc >= 2) begin
                for (int k = 0; k < 9; k++)
                    e_new[k*32 +: 32] = img[mr - 2 + k / 3][mc - 2 + k % 3];
                e_new[EW-1] = (mr == IMG_HEIGHT - 1) && (mc == IMG_WIDTH - 1);
                exp_q.push_back(e_new);
            end
            pix_idx = (pix_idx + 1) % NPIX;
        end
    end

    int          pulses = 0;
    int          fd_cnt = 0;
    logic [31:0] prev_win  [9];
    logic [31:0] first_win [9];
    logic [31:0] mid_win   [9];
    logic [31:0] last_win  [9];

    always @(negedge clk) begin
        if (edges > 0) begin
            check("valid", 32'(bus.valid_out_buf), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                e_mon = exp_q.pop_front();
                if (bus.valid_out_buf) begin
                    for (int k = 0; k < 9; k++)
                        check($sformatf("win%0d", k), dout[k], e_mon[k*32 +: 32]);
                    check("frame_done", 32'(bus.frame_done), 32'(e_mon[EW-1]));
                end
            end else begin
                check("fd_idle", 32'(bus.frame_done), 32'd0);
                if (edge_rst) begin
                    for (int k = 0; k < 9; k++)
                        check($sformatf("rst_out%0d", k), dout[k], 32'd0);
                end else if (!edge_acc) begin
                    for (int k = 0; k < 9; k++)
                        check($sformatf("hold%0d", k), dout[k], prev_win[k]);
                end
            end
            if (bus.valid_out_buf) begin
                if (pulses == 0)    first_win = dout;
                if (pulses == NWIN) mid_win = dout;
                last_win = dout;
                pulses++;
            end
            if (bus.frame_done) fd_cnt++;
            prev_win = dout;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] d);
        bus.valid_in = v;
        bus.data_in  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom());
    endtask

    // Pixel value is its raster index within the frame (row*28+col).
    task automatic send_range(input int from, input int to, input int gap_pct);
        for (int p = from; p <= to; p++) begin
            while ($urandom_range(0, 99) < gap_pct) drive(1'b0, $urandom());
            drive(1'b1, 32'(p % NPIX));
        end
    endtask

    task automatic send_random_frame(input int gap_pct);
        for (int p = 0; p < NPIX; p++) begin
            while ($urandom_range(0, 99) < gap_pct) drive(1'b0, $urandom());
            drive(1'b1, $urandom());
        end
    endtask

    task automatic do_reset(input logic v);
        rst = 1'b1;
        drive(v, $urandom());
        rst = 1'b0;
    endtask

    task automatic clear_counts();
        pulses = 0;
        fd_cnt = 0;
    endtask

    // Expected window whose top-left pixel is (base_row, 0) in the index pattern.
    task automatic check_win9(input string tag, input logic [31:0] got [9], input int base_row);
        for (int k = 0; k < 9; k++)
            check($sformatf("%s_%0d", tag, k), got[k], 32'((base_row + k / 3) * IMG_WIDTH + k % 3));
    endtask

    // ---------------- test sequence ----------------
    int p_save;

    initial begin
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_valid", 32'(bus.valid_out_buf), 32'd0);
        check("reset_fd", 32'(bus.frame_done), 32'd0);
        check("reset_d8", dout[8], 32'd0);

        // first window
        clear_counts();
        send_range(0, 57, 0);
        idle(2);
        check("t1_no_early", 32'(pulses), 32'd0);
        send_range(58, 58, 0);
        idle(1);
        check("t1_first_pulse", 32'(pulses), 32'd1);
        check_win9("t1_win", first_win, 0);

        // rest of the frame
        send_range(59, NPIX - 1, 0);
        idle(2);
        check("t2_pulses", 32'(pulses), 32'(NWIN));
        check("t2_fd_cnt", 32'(fd_cnt), 32'd1);
        check("t2_last_d0", last_win[0], 32'd725);
        check("t2_last_d8", last_win[8], 32'd783);

        // row edge (reset with valid_in high: pixel dropped)
        do_reset(1'b1);
        clear_counts();
        send_range(0, 83, 0);
        idle(1);
        p_save = pulses;
        check("t3_row2_pulses", 32'(p_save), 32'd26);
        send_range(84, 85, 0);
        idle(1);
        check("t3_edge_none", 32'(pulses), 32'(p_save));
        send_range(86, 86, 0);
        idle(1);
        check("t3_edge_pulse", 32'(pulses), 32'(p_save + 1));
        check_win9("t3_win", last_win, 1);

        // gapped frame
        do_reset(1'b0);
        clear_counts();
        send_range(0, NPIX - 1, 40);
        idle(2);
        check("t4_pulses", 32'(pulses), 32'(NWIN));
        check("t4_fd_cnt", 32'(fd_cnt), 32'd1);
        check_win9("t4_first", first_win, 0);
        check("t4_last_d0", last_win[0], 32'd725);
        check("t4_last_d8", last_win[8], 32'd783);

        // gapped frame of random data
        clear_counts();
        send_random_frame(30);
        idle(2);
        check("t4r_pulses", 32'(pulses), 32'(NWIN));
        check("t4r_fd_cnt", 32'(fd_cnt), 32'd1);

        // reset mid-frame
        do_reset(1'b0);
        send_range(0, 400, 0);
        do_reset(1'b1);
        check("t5_rst_valid", 32'(bus.valid_out_buf), 32'd0);
        check("t5_rst_fd", 32'(bus.frame_done), 32'd0);
        check("t5_rst_d0", dout[0], 32'd0);
        check("t5_rst_d8", dout[8], 32'd0);
        clear_counts();
        send_range(0, 57, 0);
        idle(1);
        check("t5_no_early", 32'(pulses), 32'd0);
        send_range(58, 58, 0);
        idle(1);
        check("t5_first_pulse", 32'(pulses), 32'd1);
        check_win9("t5_win", first_win, 0);

        // back-to-back frames
        do_reset(1'b0);
        clear_counts();
        send_range(0, 2 * NPIX - 1, 0);
        idle(2);
        check("t6_pulses", 32'(pulses), 32'(2 * NWIN));
        check("t6_fd_cnt", 32'(fd_cnt), 32'd2);
        check_win9("t6_f2_first", mid_win, 0);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
